// File: rtl/mask_collect_pkg.sv
// Shared types for the mask row collector.
//   NUM_LANES  - number of parallel mask lanes (rows interleaved mod NUM_LANES)
//   LANE_W     - width of a lane index
//   state_t    - collector FSM state
//   lane_idx_t - lane index type
package mask_collect_pkg;
  localparam int NUM_LANES = 12;
  localparam int LANE_W    = 4;

  typedef enum logic {WAIT, STREAM} state_t;
  typedef logic [LANE_W-1:0] lane_idx_t;

  function automatic lane_idx_t next_lane(input lane_idx_t l);
    return (l == lane_idx_t'(NUM_LANES-1)) ? '0 : l + 1'b1;
  endfunction
endpackage

// File: rtl/lane_fifo.sv
// Single-clock FIFO for one mask lane, registered read data.
//   gclk/grst_n : clock, synchronous active-low reset
//   push/din    : write request and data (ignored when full)
//   pop/dout    : read request (ignored when empty), dout updates the cycle after pop
//   count       : occupancy derived from registered pointers
//   full/empty  : occupancy flags
module lane_fifo #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 1024,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  gclk,
  input  logic                  grst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // extra MSB on the pointers tells full from empty when the low bits match
  logic [AW:0] wr_ptr, rd_ptr;
  logic        push_ok, pop_ok;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge gclk)
    if (push_ok) mem[wr_ptr[AW-1:0]] <= din;

  always_ff @(posedge gclk) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        dout   <= mem[rd_ptr[AW-1:0]];
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mask_row_collector.sv
// Re-serialises 12 row-interleaved 1-bit mask lanes into one raster stream.
// Each lane buffers into its own FIFO; a full row must be present on the
// current lane before it is streamed out gap-free.
//   i_CLK/i_RSTn        : clock, synchronous active-low reset
//   i_DATAk/i_VALIDk    : lane k sample and valid, k = 0..11
//   o_DATA/o_VALID      : serialised sample, one cycle after its FIFO pop
//   o_ROW_END           : last pixel of a row
//   o_FRAME_END         : last pixel of row ROWS_PER_FRAME-1
//   o_LANE              : lane the current o_DATA came from
//   o_OVERFLOW          : sticky, a write hit a full lane FIFO
module mask_row_collector
  import mask_collect_pkg::*;
#(
  parameter int DATA_WIDTH     = 1,
  parameter int IMG_WIDTH      = 640,
  parameter int ROWS_PER_FRAME = 480,
  parameter int FIFO_DEPTH     = 1024
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic [DATA_WIDTH-1:0] i_DATA0,  i_DATA1,  i_DATA2,  i_DATA3,
  input  logic [DATA_WIDTH-1:0] i_DATA4,  i_DATA5,  i_DATA6,  i_DATA7,
  input  logic [DATA_WIDTH-1:0] i_DATA8,  i_DATA9,  i_DATA10, i_DATA11,
  input  logic                  i_VALID0, i_VALID1, i_VALID2, i_VALID3,
  input  logic                  i_VALID4, i_VALID5, i_VALID6, i_VALID7,
  input  logic                  i_VALID8, i_VALID9, i_VALID10, i_VALID11,
  output logic [DATA_WIDTH-1:0] o_DATA,
  output logic                  o_VALID,
  output logic                  o_ROW_END,
  output logic                  o_FRAME_END,
  output logic [LANE_W-1:0]     o_LANE,
  output logic                  o_OVERFLOW
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(ROWS_PER_FRAME + 1);

  logic [NUM_LANES-1:0][DATA_WIDTH-1:0] lane_din, lane_dout;
  logic [NUM_LANES-1:0][CW-1:0]         lane_cnt;
  logic [NUM_LANES-1:0]                 lane_vld, lane_pop, lane_full, lane_empty;

  state_t          state;
  lane_idx_t       cur_lane;
  logic [PW-1:0]   pix_cnt;
  logic [RW-1:0]   row_cnt;
  logic            streaming, last_pix, last_row;

  assign lane_din = {i_DATA11, i_DATA10, i_DATA9, i_DATA8, i_DATA7, i_DATA6,
                     i_DATA5,  i_DATA4,  i_DATA3, i_DATA2, i_DATA1, i_DATA0};
  assign lane_vld = {i_VALID11, i_VALID10, i_VALID9, i_VALID8, i_VALID7, i_VALID6,
                     i_VALID5,  i_VALID4,  i_VALID3, i_VALID2, i_VALID1, i_VALID0};

  assign streaming = (state == STREAM);
  assign last_pix  = (pix_cnt == PW'(IMG_WIDTH - 1));
  assign last_row  = (row_cnt == RW'(ROWS_PER_FRAME - 1));

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign lane_pop[g] = streaming && (cur_lane == lane_idx_t'(g));
    lane_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .gclk  (i_CLK),
      .grst_n(i_RSTn),
      .push  (lane_vld[g]),
      .din   (lane_din[g]),
      .pop   (lane_pop[g]),
      .dout  (lane_dout[g]),
      .count (lane_cnt[g]),
      .full  (lane_full[g]),
      .empty (lane_empty[g])
    );
  end

  // dout of every lane holds until its next pop, so selecting with the
  // registered lane index keeps o_DATA aligned with o_VALID
  assign o_DATA = lane_dout[o_LANE];

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      state       <= WAIT;
      cur_lane    <= '0;
      pix_cnt     <= '0;
      row_cnt     <= '0;
      o_VALID     <= 1'b0;
      o_ROW_END   <= 1'b0;
      o_FRAME_END <= 1'b0;
      o_LANE      <= '0;
      o_OVERFLOW  <= 1'b0;
    end else begin
      o_VALID     <= streaming;
      o_ROW_END   <= streaming && last_pix;
      o_FRAME_END <= streaming && last_pix && last_row;
      o_LANE      <= cur_lane;
      o_OVERFLOW  <= o_OVERFLOW | (|(lane_vld & lane_full));
      case (state)
        WAIT: begin
          if (lane_cnt[cur_lane] >= CW'(IMG_WIDTH)) begin
            state   <= STREAM;
            pix_cnt <= '0;
          end
        end
        STREAM: begin
          pix_cnt <= pix_cnt + 1'b1;
          if (last_pix) begin
            state <= WAIT;
            // frame boundary restarts at lane 0 even when the frame height
            // is not a multiple of the lane count
            if (last_row) begin
              row_cnt  <= '0;
              cur_lane <= '0;
            end else begin
              row_cnt  <= row_cnt + 1'b1;
              cur_lane <= next_lane(cur_lane);
            end
          end
        end
        default: state <= WAIT;
      endcase
    end
  end
endmodule
